// File: rtl/multi_controller.sv
// Control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute and counts retired instructions.
module multi_controller #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       operation,
  input  logic [5:0]       func,
  input  logic             zero,
  output logic             instr_reg_we,
  output logic             instr_or_data,
  output logic             pc_reg_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [2:0]       alu_controller,
  output logic             reg_we,
  output logic             reg_write_addr,
  output logic             reg_write_data,
  output logic             mem_we,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EXEC  = 4'd8,
    S_I_WB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_ILLEGAL = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_nxt;
  state_t     w_dec_nxt;
  logic [2:0] w_dec_alu;
  logic       w_dec_shift;
  logic [2:0] r_alu;
  logic       r_shift;
  logic       r_lw;
  logic       r_bne;
  logic       w_retire;
  logic [CNT_W-1:0] r_retired;

  logic w_op_r;
  logic w_op_mem;
  logic w_op_imm;
  logic w_op_br;
  logic w_op_j;

  assign w_op_r   = (operation == 6'b000000);
  assign w_op_mem = (operation == 6'b100011) |
                    (operation == 6'b101011);
  assign w_op_imm = (operation == 6'b001000) |
                    (operation == 6'b001010);
  assign w_op_br  = (operation == 6'b000100) |
                    (operation == 6'b000101);
  assign w_op_j   = (operation == 6'b000010);

  // Opcode/func decode used on the DECODE edge
  always_comb begin
    w_dec_nxt   = S_ILLEGAL;
    w_dec_alu   = ALU_ADD;
    w_dec_shift = 1'b0;
    unique case (1'b1)
      w_op_r: begin
        w_dec_nxt = S_R_EXEC;
        case (func)
          6'b100000: w_dec_alu = ALU_ADD;
          6'b100010: w_dec_alu = ALU_SUB;
          6'b100100: w_dec_alu = ALU_AND;
          6'b100101: w_dec_alu = ALU_OR;
          6'b101010: w_dec_alu = ALU_SLT;
          6'b000000: begin
            w_dec_alu   = ALU_SLL;
            w_dec_shift = 1'b1;
          end
          6'b000010: begin
            w_dec_alu   = ALU_SRL;
            w_dec_shift = 1'b1;
          end
          6'b001000: w_dec_nxt = S_JR;
          default:   w_dec_nxt = S_ILLEGAL;
        endcase
      end
      w_op_mem: w_dec_nxt = S_MEM_ADR;
      w_op_imm: begin
        w_dec_nxt = S_I_EXEC;
        w_dec_alu = operation[1] ? ALU_SLT : ALU_ADD;
      end
      w_op_br: w_dec_nxt = S_BRANCH;
      w_op_j:  w_dec_nxt = S_JUMP;
      default: w_dec_nxt = S_ILLEGAL;
    endcase
  end

  // Latch decoded instruction class so later states are pure Moore
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu   <= ALU_ADD;
      r_shift <= 1'b0;
      r_lw    <= 1'b0;
      r_bne   <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_alu   <= w_dec_alu;
      r_shift <= w_dec_shift;
      r_lw    <= (operation == 6'b100011);
      r_bne   <= (operation == 6'b000101);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = S_FETCH;
    case (r_state)
      S_FETCH:   w_nxt = S_DECODE;
      S_DECODE:  w_nxt = w_dec_nxt;
      S_MEM_ADR: w_nxt = r_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_nxt = S_MEM_WB;
      S_MEM_WB:  w_nxt = S_FETCH;
      S_MEM_WR:  w_nxt = S_FETCH;
      S_R_EXEC:  w_nxt = S_R_WB;
      S_R_WB:    w_nxt = S_FETCH;
      S_I_EXEC:  w_nxt = S_I_WB;
      S_I_WB:    w_nxt = S_FETCH;
      S_BRANCH:  w_nxt = S_FETCH;
      S_JUMP:    w_nxt = S_FETCH;
      S_JR:      w_nxt = S_FETCH;
      S_ILLEGAL: w_nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
      S_HALT:    w_nxt = S_HALT;
      default:   w_nxt = S_FETCH;
    endcase
  end

  // States that complete an instruction
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JR: w_retire = 1'b1;
      default:                w_retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  assign retired = r_retired;

  // Per-state datapath controls, forced low while in reset
  always_comb begin
    instr_reg_we   = 1'b0;
    instr_or_data  = 1'b0;
    pc_reg_we      = 1'b0;
    pc_src         = 2'd0;
    alu_src_a      = 2'd0;
    alu_src_b      = 3'd0;
    alu_controller = ALU_AND;
    reg_we         = 1'b0;
    reg_write_addr = 1'b0;
    reg_write_data = 1'b0;
    mem_we         = 1'b0;
    halted         = 1'b0;
    case (r_state)
      S_FETCH: begin
        instr_reg_we   = 1'b1;
        alu_src_b      = 3'd1;
        alu_controller = ALU_ADD;
        pc_reg_we      = 1'b1;
      end
      S_DECODE: begin
        alu_src_b      = 3'd3;
        alu_controller = ALU_ADD;
      end
      S_MEM_ADR: begin
        alu_src_a      = 2'd1;
        alu_src_b      = 3'd2;
        alu_controller = ALU_ADD;
      end
      S_MEM_RD: begin
        alu_src_a      = 2'd1;
        alu_src_b      = 3'd2;
        alu_controller = ALU_ADD;
        instr_or_data  = 1'b1;
      end
      S_MEM_WB: begin
        reg_we         = 1'b1;
        reg_write_data = 1'b1;
      end
      S_MEM_WR: begin
        alu_src_a      = 2'd1;
        alu_src_b      = 3'd2;
        alu_controller = ALU_ADD;
        instr_or_data  = 1'b1;
        mem_we         = 1'b1;
      end
      S_R_EXEC, S_R_WB: begin
        alu_src_a      = r_shift ? 2'd2 : 2'd1;
        alu_src_b      = r_shift ? 3'd4 : 3'd0;
        alu_controller = r_alu;
        reg_we         = (r_state == S_R_WB);
        reg_write_addr = (r_state == S_R_WB);
      end
      S_I_EXEC, S_I_WB: begin
        alu_src_a      = 2'd1;
        alu_src_b      = 3'd2;
        alu_controller = r_alu;
        reg_we         = (r_state == S_I_WB);
      end
      S_BRANCH: begin
        alu_src_a      = 2'd1;
        alu_controller = ALU_SUB;
        pc_src         = 2'd1;
        pc_reg_we      = r_bne ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src    = 2'd2;
        pc_reg_we = 1'b1;
      end
      S_JR: begin
        pc_src    = 2'd3;
        pc_reg_we = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      instr_reg_we   = 1'b0;
      instr_or_data  = 1'b0;
      pc_reg_we      = 1'b0;
      pc_src         = 2'd0;
      alu_src_a      = 2'd0;
      alu_src_b      = 3'd0;
      alu_controller = ALU_AND;
      reg_we         = 1'b0;
      reg_write_addr = 1'b0;
      reg_write_data = 1'b0;
      mem_we         = 1'b0;
      halted         = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_controller.sv
// Directed bench for multi_controller.
// Three instances: default, no-halt, 4-bit counter.
module tb_multi_controller;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] fn;
  logic       zero;

  logic        irwe, iod, pcwe, rwe, rwa, rwd, mwe, hlt;
  logic [1:0]  pcs, sa;
  logic [2:0]  sb, alu;
  logic [31:0] ret;

  logic        n_irwe, n_iod, n_pcwe, n_rwe, n_rwa, n_rwd, n_mwe, n_hlt;
  logic [1:0]  n_pcs, n_sa;
  logic [2:0]  n_sb, n_alu;
  logic [31:0] n_ret;

  logic        w_irwe, w_iod, w_pcwe, w_rwe, w_rwa, w_rwd, w_mwe, w_hlt;
  logic [1:0]  w_pcs, w_sa;
  logic [2:0]  w_sb, w_alu;
  logic [3:0]  w_ret;

  logic [16:0] c_main;
  logic [16:0] c_nh;

  int n_chk;
  int n_pass;

  logic [16:0] e_fetch, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
  logic [16:0] e_rex, e_rwb, e_jmp;

  assign c_main = {irwe, iod, pcwe, pcs, sa, sb, alu,
                   rwe, rwa, rwd, mwe};
  assign c_nh   = {n_irwe, n_iod, n_pcwe, n_pcs, n_sa, n_sb,
                   n_alu, n_rwe, n_rwa, n_rwd, n_mwe};

  multi_controller dut (
    .clk(clk), .rst(rst), .operation(op), .func(fn), .zero(zero),
    .instr_reg_we(irwe), .instr_or_data(iod), .pc_reg_we(pcwe),
    .pc_src(pcs), .alu_src_a(sa), .alu_src_b(sb),
    .alu_controller(alu), .reg_we(rwe), .reg_write_addr(rwa),
    .reg_write_data(rwd), .mem_we(mwe), .halted(hlt),
    .retired(ret)
  );

  multi_controller #(.ILLEGAL_HALT(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .operation(op), .func(fn), .zero(zero),
    .instr_reg_we(n_irwe), .instr_or_data(n_iod),
    .pc_reg_we(n_pcwe), .pc_src(n_pcs), .alu_src_a(n_sa),
    .alu_src_b(n_sb), .alu_controller(n_alu), .reg_we(n_rwe),
    .reg_write_addr(n_rwa), .reg_write_data(n_rwd),
    .mem_we(n_mwe), .halted(n_hlt), .retired(n_ret)
  );

  multi_controller #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .operation(op), .func(fn), .zero(zero),
    .instr_reg_we(w_irwe), .instr_or_data(w_iod),
    .pc_reg_we(w_pcwe), .pc_src(w_pcs), .alu_src_a(w_sa),
    .alu_src_b(w_sb), .alu_controller(w_alu), .reg_we(w_rwe),
    .reg_write_addr(w_rwa), .reg_write_data(w_rwd),
    .mem_we(w_mwe), .halted(w_hlt), .retired(w_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ctl(
    input bit irw, input bit io, input bit pw, input int ps,
    input int a, input int b, input int al, input bit rw,
    input bit ra, input bit rd, input bit mw);
    return {irw, io, pw, 2'(ps), 2'(a), 3'(b), 3'(al),
            rw, ra, rd, mw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [5:0] opc, input logic z,
                        input bit pw, input int exp_ret);
    op = opc;
    step();
    step();
    zero = z;
    #1;
    chk("branch_ctl", {15'd0, c_main},
        {15'd0, ctl(0, 0, pw, 1, 1, 0, 6, 0, 0, 0, 0)});
    step();
    zero = 1'b0;
    chk("branch_ret", ret, exp_ret);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    e_fetch = ctl(1, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    e_dec   = ctl(0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
    e_madr  = ctl(0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0);
    e_mrd   = ctl(0, 1, 0, 0, 1, 2, 2, 0, 0, 0, 0);
    e_mwb   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    e_mwr   = ctl(0, 1, 0, 0, 1, 2, 2, 0, 0, 0, 1);
    e_rex   = ctl(0, 0, 0, 0, 2, 4, 3, 0, 0, 0, 0);
    e_rwb   = ctl(0, 0, 0, 0, 2, 4, 3, 1, 1, 0, 0);
    e_jmp   = ctl(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    op = 6'b000000;
    fn = 6'b100000;
    zero = 1'b0;
    step();
    step();
    chk("rst_ctl", {15'd0, c_main}, 32'd0);
    chk("rst_ret", ret, 32'd0);
    chk("rst_halt", {31'd0, hlt}, 32'd0);

    rst = 1'b1;
    #1;
    chk("fetch0", {15'd0, c_main}, {15'd0, e_fetch});

    op = 6'b100011;
    step();
    chk("lw0_dec", {15'd0, c_main}, {15'd0, e_dec});
    step();
    chk("lw0_madr", {15'd0, c_main}, {15'd0, e_madr});
    step();
    chk("lw0_mrd", {15'd0, c_main}, {15'd0, e_mrd});
    rst = 1'b0;
    #1;
    chk("abort_ctl", {15'd0, c_main}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("abort_fetch", {15'd0, c_main}, {15'd0, e_fetch});
    chk("abort_ret", ret, 32'd0);

    step();
    chk("lw_dec", {15'd0, c_main}, {15'd0, e_dec});
    step();
    chk("lw_madr", {15'd0, c_main}, {15'd0, e_madr});
    step();
    chk("lw_mrd", {15'd0, c_main}, {15'd0, e_mrd});
    step();
    chk("lw_mwb", {15'd0, c_main}, {15'd0, e_mwb});
    chk("lw_ret_pre", ret, 32'd0);
    step();
    chk("lw_fetch", {15'd0, c_main}, {15'd0, e_fetch});
    chk("lw_ret", ret, 32'd1);

    branch(6'b000100, 1'b1, 1'b1, 2);
    branch(6'b000100, 1'b0, 1'b0, 3);
    branch(6'b000101, 1'b1, 1'b0, 4);
    branch(6'b000101, 1'b0, 1'b1, 5);

    op = 6'b000000;
    fn = 6'b000000;
    step();
    step();
    chk("sll_exec", {15'd0, c_main}, {15'd0, e_rex});
    step();
    chk("sll_wb", {15'd0, c_main}, {15'd0, e_rwb});
    step();
    chk("sll_ret", ret, 32'd6);

    op = 6'b101011;
    step();
    step();
    chk("sw_madr", {15'd0, c_main}, {15'd0, e_madr});
    step();
    chk("sw_mwr", {15'd0, c_main}, {15'd0, e_mwr});
    step();
    chk("sw_ret", ret, 32'd7);

    op = 6'b000010;
    for (int k = 0; k < 16; k++) begin
      step();
      step();
      chk("j_ctl", {15'd0, c_main}, {15'd0, e_jmp});
      step();
      chk("j_ret", ret, 32'(8 + k));
      chk("j_ret_w4", {28'd0, w_ret}, 32'((8 + k) % 16));
    end

    op = 6'b111111;
    step();
    step();
    chk("ill_ctl", {15'd0, c_main}, 32'd0);
    step();
    chk("halt_ctl", {15'd0, c_main}, 32'd0);
    chk("halt_flag", {31'd0, hlt}, 32'd1);
    chk("nohalt_fetch", {15'd0, c_nh}, {15'd0, e_fetch});
    chk("nohalt_flag", {31'd0, n_hlt}, 32'd0);

    op = 6'b000010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halt_hold", {15'd0, c_main}, 32'd0);
      chk("halt_sticky", {31'd0, hlt}, 32'd1);
    end
    chk("halt_ret", ret, 32'd23);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
